// File: rtl/mem_responder_if.sv
// Memory port between the core (master) and the wait-state responder (slave).
// Clock and reset stay outside the interface as plain ports.
interface mem_responder_if;
    logic        memread;
    logic        memwrite;
    logic [63:0] memaddr;
    logic [63:0] writedata;
    logic [63:0] readdata;
    logic        ready;
    logic        err;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    modport master (
        output memread, memwrite, memaddr, writedata,
        input  readdata, ready, err, rd_count, wr_count
    );

    modport slave (
        input  memread, memwrite, memaddr, writedata,
        output readdata, ready, err, rd_count, wr_count
    );
endinterface

// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts one 64-bit load/store at a time, answers after
// WAIT_CYCLES wait states with a one-cycle ready pulse and flags misaligned/out-of-range accesses.
module mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DW    = 64;
    localparam int unsigned CW    = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [DW-1:0]    wdata_q,    wdata_d;
    logic             we_q,       we_d;
    logic             bad_q,      bad_d;
    logic [DW-1:0]    readdata_q, readdata_d;
    logic             err_q,      err_d;
    logic             ready_q,    ready_d;
    logic [CW-1:0]    rd_count_q, rd_count_d;
    logic [CW-1:0]    wr_count_q, wr_count_d;

    logic [DW-1:0]    mem_q [DEPTH];

    logic             req_c;
    logic             in_bad_c;
    logic [IDX_W-1:0] in_idx_c;
    logic             do_access_c;
    logic [IDX_W-1:0] acc_idx_c;
    logic [DW-1:0]    acc_wdata_c;
    logic             acc_we_c;
    logic             acc_bad_c;
    logic             mem_we_c;

    assign req_c    = bus.memread | bus.memwrite;
    assign in_idx_c = bus.memaddr[IDX_W+2:3];
    assign in_bad_c = (bus.memaddr[2:0] != 3'd0) | (bus.memaddr[63:3] >= 61'(DEPTH));

    // Next-state, request latching and access execution.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        bad_d       = bad_q;
        readdata_d  = readdata_q;
        err_d       = err_q;
        ready_d     = 1'b0;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        do_access_c = 1'b0;
        acc_idx_c   = idx_q;
        acc_wdata_c = wdata_q;
        acc_we_c    = we_q;
        acc_bad_c   = bad_q;

        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    idx_d   = in_idx_c;
                    wdata_d = bus.writedata;
                    we_d    = bus.memwrite;
                    bad_d   = in_bad_c;
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: the access happens on the accepting edge itself.
                        do_access_c = 1'b1;
                        acc_idx_c   = in_idx_c;
                        acc_wdata_c = bus.writedata;
                        acc_we_c    = bus.memwrite;
                        acc_bad_c   = in_bad_c;
                        state_d     = ST_RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    do_access_c = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_access_c) begin
            ready_d = 1'b1;
            if (acc_bad_c) begin
                readdata_d = '0;
                err_d      = 1'b1;
            end else begin
                readdata_d = mem_q[acc_idx_c];
                err_d      = 1'b0;
                if (acc_we_c) begin
                    wr_count_d = wr_count_q + CW'(1);
                end else begin
                    rd_count_d = rd_count_q + CW'(1);
                end
            end
        end
    end

    // A write still in flight when reset arrives must not reach the array.
    assign mem_we_c = do_access_c & ~acc_bad_c & acc_we_c & ~reset;

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[acc_idx_c] <= acc_wdata_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            bad_q      <= 1'b0;
            readdata_q <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            bad_q      <= bad_d;
            readdata_q <= readdata_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.ready    = ready_q;
    assign bus.err      = err_q;
    assign bus.rd_count = rd_count_q;
    assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances (W=0, 2, 3) driven by directed
// and randomized accesses, checked against an array-based reference model.
module tb_mem_responder;
    localparam int unsigned DEPTH = 256;

    logic       clk;
    logic [2:0] rst;

    mem_responder_if bif0 ();
    mem_responder_if bif2 ();
    mem_responder_if bif3 ();

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .reset(rst[0]), .bus(bif0.slave));
    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (.clk(clk), .reset(rst[1]), .bus(bif2.slave));
    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .reset(rst[2]), .bus(bif3.slave));

    int n_total = 0;
    int n_bad   = 0;

    logic [63:0] mdl   [3][DEPTH];
    bit          known [3][DEPTH];
    logic [31:0] rdc   [3];
    logic [31:0] wrc   [3];

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    function automatic int wait_of(input int s);
        case (s)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    task automatic drive(input int s, input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d);
        case (s)
            0: begin bif0.memread = rd; bif0.memwrite = wr; bif0.memaddr = a; bif0.writedata = d; end
            1: begin bif2.memread = rd; bif2.memwrite = wr; bif2.memaddr = a; bif2.writedata = d; end
            default: begin bif3.memread = rd; bif3.memwrite = wr; bif3.memaddr = a; bif3.writedata = d; end
        endcase
    endtask

    function automatic logic get_ready(input int s);
        case (s) 0: return bif0.ready; 1: return bif2.ready; default: return bif3.ready; endcase
    endfunction
    function automatic logic get_err(input int s);
        case (s) 0: return bif0.err; 1: return bif2.err; default: return bif3.err; endcase
    endfunction
    function automatic logic [63:0] get_rdata(input int s);
        case (s) 0: return bif0.readdata; 1: return bif2.readdata; default: return bif3.readdata; endcase
    endfunction
    function automatic logic [31:0] get_rdc(input int s);
        case (s) 0: return bif0.rd_count; 1: return bif2.rd_count; default: return bif3.rd_count; endcase
    endfunction
    function automatic logic [31:0] get_wrc(input int s);
        case (s) 0: return bif0.wr_count; 1: return bif2.wr_count; default: return bif3.wr_count; endcase
    endfunction

    // Reference behaviour of one accepted access, expressed on the word array.
    task automatic model_apply(input int s, input logic wr, input logic [63:0] a, input logic [63:0] d,
                               output logic [63:0] exp_d, output logic exp_e, output bit exp_known);
        logic [60:0] word;
        int          idx;
        word      = a[63:3];
        exp_known = 1'b1;
        if (a[2:0] != 3'd0 || word >= 61'(DEPTH)) begin
            exp_d = '0;
            exp_e = 1'b1;
        end else begin
            idx       = int'(word);
            exp_e     = 1'b0;
            exp_d     = mdl[s][idx];
            exp_known = known[s][idx];
            if (wr) begin
                mdl[s][idx]   = d;
                known[s][idx] = 1'b1;
                wrc[s]        = wrc[s] + 32'd1;
            end else begin
                rdc[s] = rdc[s] + 32'd1;
            end
        end
    endtask

    // Present a request, hold it until ready (bounded), report latency in edges from acceptance.
    task automatic access(input int s, input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d,
                          output int lat, output logic [63:0] rdata, output logic e);
        lat   = -1;
        rdata = '0;
        e     = 1'b0;
        @(negedge clk);
        drive(s, rd, wr, a, d);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (get_ready(s) === 1'b1) begin
                lat   = k;
                rdata = get_rdata(s);
                e     = get_err(s);
                break;
            end
        end
        @(negedge clk);
        drive(s, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic pulse_reset(input int s);
        @(negedge clk);
        rst[s] = 1'b1;
        @(negedge clk);
        rst[s] = 1'b0;
        rdc[s] = '0;
        wrc[s] = '0;
    endtask

    task automatic test_reset();
        rst = 3'b111;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, '0, '0);
        #1;
        for (int s = 0; s < 3; s++) begin
            n_total++;
            if (get_ready(s) !== 1'b0 || get_rdc(s) !== 32'd0) begin
                n_bad++;
                $display("FAIL in_reset[%0d]: ready=%b rd_count=%0d expected 0/0", s, get_ready(s), get_rdc(s));
            end
        end
        #14;
        rst = 3'b000;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            for (int s = 0; s < 3; s++) begin
                n_total++;
                if (get_ready(s) !== 1'b0) begin
                    n_bad++;
                    $display("FAIL idle_ready[%0d] cycle %0d: got %b expected 0", s, c, get_ready(s));
                end
            end
        end
        for (int s = 0; s < 3; s++) begin
            n_total++;
            if (get_rdata(s) !== 64'd0 || get_err(s) !== 1'b0 || get_rdc(s) !== 32'd0 || get_wrc(s) !== 32'd0) begin
                n_bad++;
                $display("FAIL idle_outputs[%0d]: readdata=%h err=%b rd=%0d wr=%0d expected all 0",
                         s, get_rdata(s), get_err(s), get_rdc(s), get_wrc(s));
            end
            rdc[s] = '0;
            wrc[s] = '0;
        end
    endtask

    task automatic test_write_read();
        int lat; logic [63:0] rd_v, ed; logic e, ee; bit kn;
        access(1, 1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, lat, rd_v, e);
        model_apply(1, 1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, ed, ee, kn);
        n_total++;
        if (lat !== 2 || e !== 1'b0 || get_wrc(1) !== 32'd1) begin
            n_bad++;
            $display("FAIL wr_0x10: lat=%0d err=%b wr_count=%0d expected 2/0/1", lat, e, get_wrc(1));
        end
        @(posedge clk); #1;
        n_total++;
        if (get_ready(1) !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_one_cycle: got %b expected 0", get_ready(1));
        end
        access(1, 1'b1, 1'b0, 64'h10, '0, lat, rd_v, e);
        model_apply(1, 1'b0, 64'h10, '0, ed, ee, kn);
        n_total++;
        if (lat !== 2 || rd_v !== 64'hDEAD_BEEF_CAFE_F00D || e !== 1'b0 || get_rdc(1) !== 32'd1) begin
            n_bad++;
            $display("FAIL rd_0x10: lat=%0d data=%h err=%b rd_count=%0d expected 2/deadbeefcafef00d/0/1",
                     lat, rd_v, e, get_rdc(1));
        end
    endtask

    task automatic test_errors();
        int lat; logic [63:0] rd_v, ed; logic e, ee; bit kn;
        access(1, 1'b0, 1'b1, 64'h0, 64'h0123_4567_89AB_CDEF, lat, rd_v, e);
        model_apply(1, 1'b1, 64'h0, 64'h0123_4567_89AB_CDEF, ed, ee, kn);
        access(1, 1'b1, 1'b0, 64'h0C, '0, lat, rd_v, e);
        model_apply(1, 1'b0, 64'h0C, '0, ed, ee, kn);
        n_total++;
        if (lat !== 2 || e !== 1'b1 || rd_v !== 64'd0 || get_rdc(1) !== 32'd1) begin
            n_bad++;
            $display("FAIL misaligned_rd: lat=%0d err=%b data=%h rd_count=%0d expected 2/1/0/1", lat, e, rd_v, get_rdc(1));
        end
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (get_err(1) !== 1'b1 || get_rdata(1) !== 64'd0) begin
            n_bad++;
            $display("FAIL err_hold: err=%b data=%h expected 1/0", get_err(1), get_rdata(1));
        end
        access(1, 1'b0, 1'b1, 64'h800, 64'hFFFF_FFFF_FFFF_FFFF, lat, rd_v, e);
        model_apply(1, 1'b1, 64'h800, 64'hFFFF_FFFF_FFFF_FFFF, ed, ee, kn);
        n_total++;
        if (e !== 1'b1 || get_wrc(1) !== 32'd2) begin
            n_bad++;
            $display("FAIL range_wr: err=%b wr_count=%0d expected 1/2", e, get_wrc(1));
        end
        access(1, 1'b1, 1'b0, 64'h0, '0, lat, rd_v, e);
        model_apply(1, 1'b0, 64'h0, '0, ed, ee, kn);
        n_total++;
        if (rd_v !== 64'h0123_4567_89AB_CDEF || e !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_0x0_after_bad_wr: data=%h err=%b expected 0123456789abcdef/0", rd_v, e);
        end
        access(1, 1'b0, 1'b1, 64'h7F8, 64'h77, lat, rd_v, e);
        model_apply(1, 1'b1, 64'h7F8, 64'h77, ed, ee, kn);
        access(1, 1'b1, 1'b0, 64'h7F8, '0, lat, rd_v, e);
        model_apply(1, 1'b0, 64'h7F8, '0, ed, ee, kn);
        n_total++;
        if (rd_v !== 64'h77 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL top_word: data=%h err=%b expected 77/0", rd_v, e);
        end
    endtask

    task automatic test_simultaneous();
        int lat; logic [63:0] rd_v, ed; logic e, ee; bit kn;
        logic [31:0] rd0, wr0;
        access(1, 1'b0, 1'b1, 64'h18, 64'h5, lat, rd_v, e);
        model_apply(1, 1'b1, 64'h18, 64'h5, ed, ee, kn);
        rd0 = rdc[1];
        wr0 = wrc[1];
        access(1, 1'b1, 1'b1, 64'h18, 64'h1, lat, rd_v, e);
        model_apply(1, 1'b1, 64'h18, 64'h1, ed, ee, kn);
        n_total++;
        if (rd_v !== 64'h5 || get_wrc(1) !== wr0 + 32'd1 || get_rdc(1) !== rd0) begin
            n_bad++;
            $display("FAIL rdwr_both: data=%h wr=%0d rd=%0d expected 5/%0d/%0d", rd_v, get_wrc(1), get_rdc(1), wr0 + 1, rd0);
        end
        access(1, 1'b1, 1'b0, 64'h18, '0, lat, rd_v, e);
        model_apply(1, 1'b0, 64'h18, '0, ed, ee, kn);
        n_total++;
        if (rd_v !== 64'h1) begin
            n_bad++;
            $display("FAIL rdwr_readback: data=%h expected 1", rd_v);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] rd_v, ed; logic e, ee; bit kn;
        access(2, 1'b0, 1'b1, 64'h20, 64'h55, lat, rd_v, e);
        model_apply(2, 1'b1, 64'h20, 64'h55, ed, ee, kn);
        n_total++;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL w3_latency: got %0d expected 3", lat);
        end
        @(negedge clk);
        drive(2, 1'b0, 1'b1, 64'h20, 64'hAA);
        @(posedge clk);
        @(posedge clk); #1;
        rst[2] = 1'b1;
        drive(2, 1'b0, 1'b0, '0, '0);
        #1;
        n_total++;
        if (get_rdc(2) !== 32'd0 || get_wrc(2) !== 32'd0 || get_rdata(2) !== 64'd0 || get_ready(2) !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_clear: rd=%0d wr=%0d data=%h ready=%b expected 0", get_rdc(2), get_wrc(2),
                     get_rdata(2), get_ready(2));
        end
        rdc[2] = '0;
        wrc[2] = '0;
        @(negedge clk);
        rst[2] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            n_total++;
            if (get_ready(2) !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_reset_no_ready cycle %0d: got %b expected 0", c, get_ready(2));
            end
        end
        access(2, 1'b1, 1'b0, 64'h20, '0, lat, rd_v, e);
        model_apply(2, 1'b0, 64'h20, '0, ed, ee, kn);
        n_total++;
        if (rd_v !== 64'h55 || get_rdc(2) !== 32'd1 || get_wrc(2) !== 32'd0) begin
            n_bad++;
            $display("FAIL mid_reset_readback: data=%h rd=%0d wr=%0d expected 55/1/0", rd_v, get_rdc(2), get_wrc(2));
        end
    endtask

    task automatic test_random(input int s);
        int lat; logic [63:0] a, d, t, rd_v, ed; logic e, ee, wr, rd; bit kn;
        int unsigned idx;
        for (int i = 0; i < 56; i++) begin
            idx = $urandom_range(0, 15);
            d   = {$urandom, $urandom};
            t   = {$urandom, $urandom};
            wr  = 1'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            if (!wr) rd = 1'b1;
            case ($urandom_range(0, 9))
                0:       a = 64'(idx * 8 + $urandom_range(1, 7));
                1:       a = 64'((DEPTH + idx) * 8);
                2:       a = {1'b1, t[62:3], 3'b000};
                default: a = 64'(idx * 8);
            endcase
            if (i < 16) begin
                wr = 1'b1;
                rd = 1'b0;
                a  = 64'(i * 8);
            end
            access(s, rd, wr, a, d, lat, rd_v, e);
            model_apply(s, wr, a, d, ed, ee, kn);
            n_total++;
            if (lat !== wait_of(s) || e !== ee || (kn && rd_v !== ed) ||
                get_rdc(s) !== rdc[s] || get_wrc(s) !== wrc[s]) begin
                n_bad++;
                $display("FAIL rand[%0d] op %0d addr=%h wr=%b: lat=%0d err=%b data=%h rd=%0d wr=%0d expected lat=%0d err=%b data=%h rd=%0d wr=%0d",
                         s, i, a, wr, lat, e, rd_v, get_rdc(s), get_wrc(s), wait_of(s), ee, ed, rdc[s], wrc[s]);
            end
        end
    endtask

    task automatic test_back_to_back(input int s, input int n);
        logic [63:0] ed; logic ee, exp_r; bit kn;
        int w;
        w = wait_of(s);
        pulse_reset(s);
        @(negedge clk);
        drive(s, 1'b1, 1'b0, 64'h8, '0);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            exp_r = ((k % (w + 2)) == w);
            if (exp_r) model_apply(s, 1'b0, 64'h8, '0, ed, ee, kn);
            n_total++;
            if (get_ready(s) !== exp_r || (exp_r && kn && get_rdata(s) !== ed)) begin
                n_bad++;
                $display("FAIL b2b[%0d] edge %0d: ready=%b data=%h expected ready=%b data=%h",
                         s, k, get_ready(s), get_rdata(s), exp_r, ed);
            end
        end
        @(negedge clk);
        drive(s, 1'b0, 1'b0, '0, '0);
        n_total++;
        if (get_rdc(s) !== rdc[s]) begin
            n_bad++;
            $display("FAIL b2b_count[%0d]: got %0d expected %0d", s, get_rdc(s), rdc[s]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_errors();
        test_simultaneous();
        test_reset_mid();
        for (int s = 0; s < 3; s++) test_random(s);
        test_back_to_back(0, 6);
        test_back_to_back(1, 12);
        test_back_to_back(2, 10);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Wait-state memory responder answering the 64-bit load/store requests issued by the multi-cycle MIPS core. Sits between `top`'s memory port (`memaddr`, `writedata`, `memwrite`) and a word-addressed storage array, and returns `readdata` with a `ready` completion strobe after a programmable number of wait cycles. It lets the core's fetch and memory states be exercised against non-zero memory latency, and flags misaligned or out-of-range accesses.

## Interface
- `DEPTH`, 256: storage size in 64-bit words; power of two, at least 2.
- `WAIT_CYCLES`, 2: wait states inserted between request acceptance and `ready`; 0..15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `memread`  in  1  read request.
- `memwrite`  in  1  write request.
- `memaddr`  in  64  byte address; bits [2:0] must be 0.
- `writedata`  in  64  store data.
- `readdata`  out  64  load data; valid while `ready`=1.
- `ready`  out  1  access complete; high for exactly one cycle per accepted request.
- `err`  out  1  accompanies `ready`; high if the access was misaligned or out of range.
- `rd_count`  out  32  completed reads, error-free only; wraps 2^32-1 -> 0.
- `wr_count`  out  32  completed writes, error-free only; wraps 2^32-1 -> 0.

## Operation
- States: IDLE, WAIT, RESP.
- In IDLE, a request is `memread | memwrite`. On a clock edge with a request present:
  - latch `memaddr`, `writedata`, and `we = memwrite`;
  - compute `bad = (memaddr[2:0] != 0) | (memaddr[63:3] >= DEPTH)`;
  - if `WAIT_CYCLES`=0, perform the access and go to RESP;
  - otherwise load `cnt = WAIT_CYCLES-1` and go to WAIT.
- In WAIT:
  - if `cnt`=0, perform the access and go to RESP;
  - otherwise decrement `cnt`.
- Performing the access, which always uses the latched values:
  - if `bad`: no array write; `readdata` <= 0; `err` <= 1.
  - else if `we`: write the word at index `addr[3+log2(DEPTH)-1:3]`; `readdata` <= the old word at that index; `wr_count`++.
  - else: `readdata` <= the word at that index; `rd_count`++.
- RESP: `ready`=1 for this single cycle, then IDLE unconditionally. Requests presented during WAIT or RESP are ignored. The core holds its request until `ready`, so it is re-sampled in IDLE the cycle after RESP.
- `memread` and `memwrite` both high: treated as a write.
- `readdata` and `err` hold their last values until the next access is performed.
- Reset, including mid-access:
  - state <= IDLE; `ready`, `err`, `readdata`, `rd_count`, `wr_count` <= 0;
  - a pending write is dropped;
  - array contents are not cleared.

## Timing
- Request sampled at edge t → `ready`, `readdata` and `err` update at edge t+`WAIT_CYCLES`. They are visible during cycle [t+W, t+W+1).
- The array write also commits at edge t+W.
- Back-to-back throughput: one access per W+2 cycles (accept, W waits, RESP, re-accept in IDLE). With W=0, `ready` rises at the same edge the request is accepted, then one IDLE cycle follows.
- All outputs are registered; there is no combinational input→output path.
- Async reset takes effect immediately, independent of `clk`.

## Test plan
- Reset then idle. Assert `reset` for 15 ns (10 ns clock), keep `memread`=`memwrite`=0 for 10 cycles → all outputs stay 0 and no `ready` pulse occurs.
- Write/read, W=2:
  - write `memaddr`=0x10, `writedata`=0xDEADBEEF_CAFEF00D, request at edge t → `ready` 1 only during cycle [t+2, t+3), `err`=0, `wr_count`=1;
  - then read 0x10 → `readdata`=0xDEADBEEF_CAFEF00D, `rd_count`=1.
- Errors:
  - read 0x0C (misaligned) → `ready` and `err`=1, `readdata`=0, `rd_count` unchanged;
  - write to 0x800 with DEPTH=256 → `err`=1, no array change; a later read of 0x0 returns its prior value.
- Simultaneous read and write. `memread`=`memwrite`=1, addr 0x18, data 0x1, old word 0x5 → `readdata`=0x5, then a subsequent read returns 0x1; `wr_count`+1, `rd_count` unchanged.
- Reset mid-access. W=3, write 0x20←0xAA, assert `reset` one cycle after acceptance → `ready` never pulses; a read of 0x20 afterwards returns the pre-write value; counters are 0.
- W=0 back-to-back. Hold `memread` high for 6 cycles → `ready` toggles 1,0,1,0,…, and `rd_count`=3 after 6 edges.
